// File: rtl/cdb_broadcast_if.sv
// Purpose : FU-result / CDB-broadcast bundle between the execute stage and the CDB driver.
// Latency : none (wires only).
// Backpressure: fu_ready per FU; the CDB side has no backpressure because every consumer snoops.
// Ports   : fu_valid/fu_tag/fu_value (FU -> CDB), fu_ready (CDB -> FU),
//           cdb_packet {reg_tag, reg_value}, cdb_valid, cdb_src (CDB -> consumers).
interface cdb_broadcast_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32
);
    localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] reg_tag;
        logic [XLEN-1:0]  reg_value;
    } cdb_packet_t;

    logic [NUM_FU-1:0]             fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0]   fu_value;
    logic [NUM_FU-1:0]             fu_ready;

    cdb_packet_t                   cdb_packet;
    logic                          cdb_valid;
    logic [SRC_W-1:0]              cdb_src;

    // Execute-stage side: presents results, watches the bus.
    modport master (
        output fu_valid, fu_tag, fu_value,
        input  fu_ready, cdb_packet, cdb_valid, cdb_src
    );

    // CDB driver side.
    modport slave (
        input  fu_valid, fu_tag, fu_value,
        output fu_ready, cdb_packet, cdb_valid, cdb_src
    );
endinterface

// File: rtl/cdb_broadcast.sv
// Purpose : Common Data Bus transmit end; one 1-entry hold buffer per FU, round-robin onto a registered CDB packet.
// Latency : FU handshake at edge t -> broadcast visible after edge t+1; one broadcast per cycle total.
// Backpressure: fu_ready[i] = ~hold_valid[i] | grant[i]; a full, ungranted buffer stalls its FU.
// Ports   : clock, reset (sync, active-high), squash (flush all held results),
//           bus (cdb_broadcast_if.slave: FU results in, fu_ready out, CDB packet/valid/src out).
module cdb_broadcast #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    cdb_broadcast_if.slave       bus
);
    localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]            hold_valid;
    logic [NUM_FU-1:0][TAG_W-1:0] hold_tag;
    logic [NUM_FU-1:0][XLEN-1:0]  hold_value;

    logic [SRC_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] grant;
    logic [SRC_W-1:0]  win;
    logic              any_grant;

    logic [TAG_W-1:0]  pkt_tag_q;
    logic [XLEN-1:0]   pkt_value_q;
    logic              pkt_vld_q;
    logic [SRC_W-1:0]  pkt_src_q;

    // Round-robin scan starting at rr_ptr; the first held result wins.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_c;
        grant     = '0;
        win       = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_c     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            idx_c = SRC_W'(idx);
            if (!any_grant && hold_valid[idx_c]) begin
                any_grant = 1'b1;
                win       = idx_c;
            end
        end
        if (any_grant) grant[win] = 1'b1;
    end

    // Ready depends only on state and grant, so a buffer being drained this
    // edge can be refilled on the same edge.
    assign bus.fu_ready   = ~hold_valid | grant;

    assign bus.cdb_packet = {pkt_tag_q, pkt_value_q};
    assign bus.cdb_valid  = pkt_vld_q;
    assign bus.cdb_src    = pkt_src_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid  <= '0;
            hold_tag    <= '0;
            hold_value  <= '0;
            rr_ptr      <= '0;
            pkt_vld_q   <= 1'b0;
            pkt_tag_q   <= '0;
            pkt_value_q <= '0;
            pkt_src_q   <= '0;
        end else if (squash) begin
            // Flush wins over both capture and broadcast; rr_ptr and cdb_src keep their value.
            hold_valid  <= '0;
            pkt_vld_q   <= 1'b0;
            pkt_tag_q   <= '0;
            pkt_value_q <= '0;
        end else begin
            if (any_grant) begin
                pkt_vld_q   <= 1'b1;
                pkt_tag_q   <= hold_tag[win];
                pkt_value_q <= hold_value[win];
                pkt_src_q   <= win;
                rr_ptr      <= (win == SRC_W'(NUM_FU - 1)) ? '0 : win + 1'b1;
            end else begin
                pkt_vld_q   <= 1'b0;
                pkt_tag_q   <= '0;
                pkt_value_q <= '0;
            end

            for (int i = 0; i < NUM_FU; i++) begin
                if (grant[i]) hold_valid[i] <= 1'b0;
                // A tag-0 result is handshaken but never stored; if it lands on a
                // granted slot the clear above still takes effect.
                if (bus.fu_valid[i] && bus.fu_ready[i] && (bus.fu_tag[i] != '0)) begin
                    hold_valid[i] <= 1'b1;
                    hold_tag[i]   <= bus.fu_tag[i];
                    hold_value[i] <= bus.fu_value[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcast.sv
module tb_cdb_broadcast;
    localparam int NUM_FU = 4;
    localparam int TAG_W  = 5;
    localparam int XLEN   = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic squash = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    cdb_broadcast_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

    cdb_broadcast #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_fu();
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_value = '0;
    endtask

    task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        bus.fu_valid[i] = 1'b1;
        bus.fu_tag[i]   = t;
        bus.fu_value[i] = v;
    endtask

    task automatic check_bus(input string tag, input logic v, input logic [TAG_W-1:0] t,
                             input logic [XLEN-1:0] val, input logic [1:0] src);
        check({tag, ".valid"}, bus.cdb_valid, v);
        check({tag, ".tag"},   bus.cdb_packet.reg_tag, t);
        check({tag, ".value"}, bus.cdb_packet.reg_value, val);
        if (v) check({tag, ".src"}, bus.cdb_src, src);
    endtask

    initial begin
        clear_fu();
        #1;

        // 1: reset with all FUs asserting results
        reset = 1'b1;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, TAG_W'(i + 1), 32'hA0 + i);
        step();
        step();
        check("rst.valid", bus.cdb_valid, 1'b0);
        check("rst.tag",   bus.cdb_packet.reg_tag, 0);
        check("rst.value", bus.cdb_packet.reg_value, 0);
        check("rst.src",   bus.cdb_src, 0);
        check("rst.ready", bus.fu_ready, 4'hF);
        reset = 1'b0;
        clear_fu();
        step();
        check("post_rst.valid0", bus.cdb_valid, 1'b0);
        check("post_rst.ready",  bus.fu_ready, 4'hF);
        step();
        check("post_rst.valid1", bus.cdb_valid, 1'b0);

        // 2: single result from FU2
        set_fu(2, 5'd5, 32'hDEAD_BEEF);
        step();
        clear_fu();
        check("single.lat1", bus.cdb_valid, 1'b0);
        step();
        check_bus("single.bc", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd2);
        step();
        check_bus("single.idle", 1'b0, 5'd0, 32'h0, 2'd0);

        // 3: four-way contention from rr_ptr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, TAG_W'(i + 1), 32'h1000 + i);
        step();
        clear_fu();
        check("cont.ready0", bus.fu_ready, 4'b0001);
        check("cont.idle0", bus.cdb_valid, 1'b0);
        step();
        check_bus("cont.bc1", 1'b1, 5'd1, 32'h1000, 2'd0);
        check("cont.ready1", bus.fu_ready, 4'b0011);
        step();
        check_bus("cont.bc2", 1'b1, 5'd2, 32'h1001, 2'd1);
        check("cont.ready2", bus.fu_ready, 4'b0111);
        step();
        check_bus("cont.bc3", 1'b1, 5'd3, 32'h1002, 2'd2);
        check("cont.ready3", bus.fu_ready, 4'b1111);
        step();
        check_bus("cont.bc4", 1'b1, 5'd4, 32'h1003, 2'd3);
        step();
        check_bus("cont.idle", 1'b0, 5'd0, 32'h0, 2'd0);

        // 4: FU0/FU1 streaming continuously, rr_ptr=0
        set_fu(0, 5'd7, 32'h7000_0007);
        set_fu(1, 5'd9, 32'h9000_0009);
        step();
        for (int n = 0; n < 6; n++) begin
            step();
            if (n % 2 == 0) check_bus($sformatf("rr.bc%0d", n), 1'b1, 5'd7, 32'h7000_0007, 2'd0);
            else            check_bus($sformatf("rr.bc%0d", n), 1'b1, 5'd9, 32'h9000_0009, 2'd1);
        end
        clear_fu();
        step();
        check_bus("rr.drain0", 1'b1, 5'd7, 32'h7000_0007, 2'd0);
        step();
        check_bus("rr.drain1", 1'b1, 5'd9, 32'h9000_0009, 2'd1);
        step();
        check_bus("rr.idle", 1'b0, 5'd0, 32'h0, 2'd0);

        // 5: squash with tags 3,4,6 held (rr_ptr=2)
        set_fu(0, 5'd3, 32'h33);
        set_fu(2, 5'd4, 32'h44);
        set_fu(3, 5'd6, 32'h66);
        step();
        clear_fu();
        check("sq.ready_pre", bus.fu_ready, 4'b0110);
        squash = 1'b1;
        step();
        squash = 1'b0;
        check_bus("sq.after", 1'b0, 5'd0, 32'h0, 2'd0);
        check("sq.ready", bus.fu_ready, 4'hF);
        for (int n = 0; n < 4; n++) begin
            step();
            check($sformatf("sq.quiet%0d", n), bus.cdb_valid, 1'b0);
        end
        set_fu(1, 5'd8, 32'h8888);
        step();
        clear_fu();
        step();
        check_bus("sq.new", 1'b1, 5'd8, 32'h8888, 2'd1);
        step();
        check("sq.new_idle", bus.cdb_valid, 1'b0);

        // 6: tag 0 is accepted and discarded
        check("tag0.ready_pre", bus.fu_ready[3], 1'b1);
        set_fu(3, 5'd0, 32'h1234);
        step();
        clear_fu();
        check("tag0.ready_post", bus.fu_ready, 4'hF);
        check("tag0.valid0", bus.cdb_valid, 1'b0);
        step();
        check_bus("tag0.valid1", 1'b0, 5'd0, 32'h0, 2'd0);
        step();
        check("tag0.valid2", bus.cdb_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
